// File: rtl/regs_wport_arbiter.sv
// Shares the register-file write port between EX write-back (always wins) and JTAG accesses.
// Optional QED_MIRROR_EN: a JTAG write to x1..x15 is duplicated into x16..x31.
module regs_wport_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_we_i,
  input  logic [4:0]  ex_waddr_i,
  input  logic [31:0] ex_wdata_i,
  input  logic        jtag_req_i,
  input  logic        jtag_we_i,
  input  logic [4:0]  jtag_addr_i,
  input  logic [31:0] jtag_wdata_i,
  output logic        jtag_ack_o,
  output logic [31:0] jtag_rdata_o,
  input  logic [31:0] rf_rdata_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic [4:0]  rf_jtag_addr_o,
  output logic        hold_ex_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PEND   = 2'd1,
`ifdef QED_MIRROR_EN
    ST_MIRROR = 2'd2,
`endif
    ST_ACK    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        cap_we_q, cap_we_d;
  logic [4:0]  cap_addr_q, cap_addr_d;
  logic [31:0] cap_data_q, cap_data_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  starve_q, starve_d;
  logic        hold_q, hold_d;
  logic        ack_q, ack_d;

  logic        ex_slot;
  logic        jtag_wr;
  logic [4:0]  jtag_waddr;
  logic [3:0]  starve_inc;
  logic        starve_hit;

  assign ex_slot    = ex_we_i && (ex_waddr_i != '0);
  assign starve_inc = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;
  assign starve_hit = ({28'd0, starve_inc} >= STARVE_MAX);

  always_comb begin
    state_d    = state_q;
    cap_we_d   = cap_we_q;
    cap_addr_d = cap_addr_q;
    cap_data_d = cap_data_q;
    rdata_d    = rdata_q;
    starve_d   = starve_q;
    hold_d     = hold_q;
    ack_d      = ack_q;
    jtag_wr    = 1'b0;
    jtag_waddr = cap_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (jtag_req_i) begin
          cap_we_d   = jtag_we_i;
          cap_addr_d = jtag_addr_i;
          cap_data_d = jtag_wdata_i;
          state_d    = ST_PEND;
        end
      end
      ST_PEND: begin
        if (!cap_we_q) begin
          rdata_d = rf_rdata_i;
          state_d = ST_ACK;
        end else if (cap_addr_q == '0) begin
          state_d = ST_ACK;
        end else if (!ex_slot) begin
          jtag_wr  = 1'b1;
          starve_d = '0;
          hold_d   = 1'b0;
`ifdef QED_MIRROR_EN
          state_d  = cap_addr_q[4] ? ST_ACK : ST_MIRROR;
`else
          state_d  = ST_ACK;
`endif
        end else begin
          starve_d = starve_inc;
          hold_d   = starve_hit;
        end
      end
`ifdef QED_MIRROR_EN
      ST_MIRROR: begin
        if (!ex_slot) begin
          jtag_wr    = 1'b1;
          jtag_waddr = {1'b1, cap_addr_q[3:0]};
          state_d    = ST_ACK;
        end else begin
          starve_d = starve_inc;
          hold_d   = starve_hit;
        end
      end
`endif
      ST_ACK: begin
        if (!jtag_req_i) begin
          state_d = ST_IDLE;
          ack_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Every exit from PEND/MIRROR lands in ACK, so the ack and starvation clear share one place.
    if ((state_d == ST_ACK) && (state_q != ST_ACK)) begin
      ack_d    = 1'b1;
      starve_d = '0;
      hold_d   = 1'b0;
    end
  end

  always_comb begin
    if (jtag_wr) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = jtag_waddr;
      rf_wdata_o = cap_data_q;
    end else begin
      rf_we_o    = ex_we_i;
      rf_waddr_o = ex_waddr_i;
      rf_wdata_o = ex_wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cap_we_q   <= 1'b0;
      cap_addr_q <= '0;
      cap_data_q <= '0;
      rdata_q    <= '0;
      starve_q   <= '0;
      hold_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cap_we_q   <= cap_we_d;
      cap_addr_q <= cap_addr_d;
      cap_data_q <= cap_data_d;
      rdata_q    <= rdata_d;
      starve_q   <= starve_d;
      hold_q     <= hold_d;
      ack_q      <= ack_d;
    end
  end

  assign jtag_ack_o     = ack_q;
  assign jtag_rdata_o   = rdata_q;
  assign rf_jtag_addr_o = cap_addr_q;
  assign hold_ex_o      = hold_q;

endmodule

// File: tb/tb_regs_wport_arbiter.sv
// Bench for regs_wport_arbiter: directed table, hand sequences and random traffic vs a transaction model.
`timescale 1ns/1ps
module tb_regs_wport_arbiter;
  localparam int unsigned SMAX = 4;
`ifdef QED_MIRROR_EN
  localparam bit MIR = 1'b1;
`else
  localparam bit MIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_we;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic        req, jwe;
  logic [4:0]  jaddr;
  logic [31:0] jwdata;
  logic        ack;
  logic [31:0] rdata;
  logic [31:0] rf_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rf_jaddr;
  logic        hold;

  regs_wport_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
    .jtag_req_i(req), .jtag_we_i(jwe), .jtag_addr_i(jaddr), .jtag_wdata_i(jwdata),
    .jtag_ack_o(ack), .jtag_rdata_o(rdata), .rf_rdata_i(rf_rdata),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .rf_jtag_addr_o(rf_jaddr), .hold_ex_o(hold)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: pending JTAG writes still owed, access phase, blocked-cycle count.
  typedef struct packed {logic [4:0] a; logic [31:0] d;} wr_t;
  wr_t         wq[$];
  int          phase = 0;   // 0 idle, 1 access outstanding, 2 acknowledged
  int          blocked = 0;
  bit          m_rd = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [4:0]  m_cap = '0;
  int          dut_jw = 0;

  task automatic model_reset();
    phase = 0; blocked = 0; m_rd = 1'b0; m_rdata = '0; m_cap = '0; wq.delete();
  endtask

  // One clock: check the combinational port before the edge, then registered outputs after it.
  task automatic step();
    bit slot, wrote, done, req_s, jwe_s;
    logic [4:0]  ja_s;
    logic [31:0] jd_s, rd_s, e_we, e_a, e_d;
    wr_t w;
    @(negedge clk);
    slot = ex_we && (ex_waddr != 5'd0);
    req_s = req; jwe_s = jwe; ja_s = jaddr; jd_s = jwdata; rd_s = rf_rdata;
    wrote = 1'b0; done = 1'b0;
    if (slot) begin
      e_we = 1; e_a = {27'd0, ex_waddr}; e_d = ex_wdata;
    end else if (phase == 1 && wq.size() > 0) begin
      w = wq.pop_front(); e_we = 1; e_a = {27'd0, w.a}; e_d = w.d; wrote = 1'b1;
    end else begin
      e_we = {31'd0, ex_we}; e_a = {27'd0, ex_waddr}; e_d = ex_wdata;
    end
    chk("rf_we", {31'd0, rf_we}, e_we);
    chk("rf_waddr", {27'd0, rf_waddr}, e_a);
    chk("rf_wdata", rf_wdata, e_d);
    if (rf_we === 1'b1 && !slot && !(ex_we && rf_waddr === 5'd0)) dut_jw++;
    if (phase == 1) begin
      if (wrote) blocked = 0;
      else if (slot && wq.size() > 0) blocked = (blocked < 15) ? blocked + 1 : 15;
      done = (wq.size() == 0);
    end
    @(posedge clk); #1;
    case (phase)
      0: if (req_s) begin
        phase = 1; blocked = 0; m_cap = ja_s; m_rd = !jwe_s; wq.delete();
        if (jwe_s && ja_s != 5'd0) begin
          wq.push_back('{a: ja_s, d: jd_s});
          if (MIR && !ja_s[4]) wq.push_back('{a: ja_s | 5'd16, d: jd_s});
        end
      end
      1: if (done) begin
        phase = 2; blocked = 0;
        if (m_rd) m_rdata = rd_s;
      end
      default: if (!req_s) phase = 0;
    endcase
    chk("ack", {31'd0, ack}, {31'd0, phase == 2});
    chk("hold", {31'd0, hold}, {31'd0, (phase == 1 && blocked >= int'(SMAX))});
    chk("rdata", rdata, m_rdata);
    chk("rf_jaddr", {27'd0, rf_jaddr}, {27'd0, m_cap});
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    while (ack !== 1'b1 && n < 60) begin step(); n++; end
    if (ack !== 1'b1) begin n_cmp++; n_err++; $display("FAIL ack_timeout: ack never rose"); end
  endtask

  task automatic release_req();
    int k;
    req = 1'b0; ex_we = 1'b0; k = 0;
    while (ack !== 1'b0 && k < 5) begin step(); k++; end
    step();
    chk("ack_release", {31'd0, ack}, 32'd0);
  endtask

  task automatic run_xact(input bit we, input logic [4:0] a, input logic [31:0] d,
                          input logic [31:0] rdin, input int unsigned blk, input logic [4:0] exa,
                          input bit rnd, output int lat_o, output int nw_o);
    int unsigned k;
    dut_jw = 0;
    req = 1'b1; jwe = we; jaddr = a; jwdata = d; rf_rdata = rdin; ex_we = 1'b0;
    step();
    jwe = 1'($urandom_range(0, 1)); jaddr = 5'($urandom_range(0, 31)); jwdata = $urandom;
    k = 0;
    while (ack !== 1'b1 && k < 60) begin
      if (rnd) begin
        ex_we = !hold && ($urandom_range(0, 9) < 6);
        ex_waddr = 5'($urandom_range(0, 31)); ex_wdata = $urandom;
      end else begin
        ex_we = (k < blk); ex_waddr = exa; ex_wdata = $urandom;
      end
      step(); k++;
    end
    if (ack !== 1'b1) begin n_cmp++; n_err++; $display("FAIL xact_timeout: addr %0d", a); end
    lat_o = int'(k); nw_o = dut_jw;
    ex_we = 1'b0;
    if (rnd) repeat ($urandom_range(0, 3)) step();
    release_req();
  endtask

  typedef struct {
    bit we; logic [4:0] a; logic [31:0] d; logic [31:0] rdin;
    int unsigned blk; logic [4:0] exa; int unsigned lat; int unsigned nw;
  } vec_t;
  vec_t tbl[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, nw, n;
    int unsigned elat, enw;
    bit mir;
    logic [4:0] ra;
    bit rwe;

    tbl[0] = '{1'b1, 5'd3,  32'hDEADBEEF, 32'h0,        0, 5'd7, 1, 1};
    tbl[1] = '{1'b0, 5'd5,  32'h0,        32'h00001234, 0, 5'd7, 1, 0};
    tbl[2] = '{1'b1, 5'd0,  32'h11111111, 32'h0,        0, 5'd7, 1, 0};
    tbl[3] = '{1'b1, 5'd9,  32'hCAFEF00D, 32'h0,        2, 5'd7, 3, 1};
    tbl[4] = '{1'b1, 5'd20, 32'h0BADBEEF, 32'h0,        1, 5'd2, 2, 1};
    tbl[5] = '{1'b1, 5'd4,  32'h44444444, 32'h0,        3, 5'd0, 1, 1};
    tbl[6] = '{1'b0, 5'd31, 32'h0,        32'hA5A5A5A5, 2, 5'd7, 1, 0};
    tbl[7] = '{1'b1, 5'd15, 32'h15151515, 32'h0,        3, 5'd1, 4, 1};

    rst = 1'b1; ex_we = 1'b0; ex_waddr = '0; ex_wdata = '0;
    req = 1'b0; jwe = 1'b0; jaddr = '0; jwdata = '0; rf_rdata = 32'h5555AAAA;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_hold", {31'd0, hold}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_jaddr", {27'd0, rf_jaddr}, 32'd0);
    ex_we = 1'b1; ex_waddr = 5'd9; ex_wdata = 32'h99990000;
    #1;
    chk("rst_pass_we", {31'd0, rf_we}, 32'd1);
    chk("rst_pass_addr", {27'd0, rf_waddr}, 32'd9);
    chk("rst_pass_data", rf_wdata, 32'h99990000);
    ex_we = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    model_reset();

    foreach (tbl[i]) begin
      run_xact(tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].rdin, tbl[i].blk, tbl[i].exa, 1'b0, lat, nw);
      mir = MIR && tbl[i].we && tbl[i].a != 5'd0 && !tbl[i].a[4];
      elat = tbl[i].lat + (mir ? 1 : 0);
      enw  = tbl[i].nw + (mir ? 1 : 0);
      chk($sformatf("tbl%0d_lat", i), lat, elat);
      chk($sformatf("tbl%0d_nwr", i), nw, enw);
      if (!tbl[i].we) chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].rdin);
    end

    // Starvation: EX keeps writing x7 until hold appears, then drops for one cycle.
    dut_jw = 0;
    req = 1'b1; jwe = 1'b1; jaddr = 5'd6; jwdata = 32'h66666666; ex_we = 1'b0;
    step();
    ex_we = 1'b1; ex_waddr = 5'd7; ex_wdata = 32'h77777777;
    for (int i = 0; i < int'(SMAX); i++) begin
      chk("starve_no_hold_early", {31'd0, hold}, 32'd0);
      step();
    end
    chk("starve_hold", {31'd0, hold}, 32'd1);
    chk("starve_no_jtag_yet", dut_jw, 32'd0);
    ex_we = 1'b0;
    step();
    chk("starve_clear", {31'd0, hold}, 32'd0);
    chk("starve_landed", dut_jw, 32'd1);
    wait_ack(n);
    release_req();

    // Handshake: request held long after ack must not start a second access.
    dut_jw = 0;
    req = 1'b1; jwe = 1'b1; jaddr = 5'd2; jwdata = 32'h22222222;
    step();
    wait_ack(n);
    for (int i = 0; i < 10; i++) begin
      jwe = 1'b1; jaddr = 5'($urandom_range(1, 31)); jwdata = $urandom;
      step();
      chk("hs_ack_held", {31'd0, ack}, 32'd1);
    end
    chk("hs_no_second", dut_jw, MIR ? 32'd2 : 32'd1);
    req = 1'b0;
    step();
    chk("hs_ack_fall", {31'd0, ack}, 32'd0);
    req = 1'b1; jwe = 1'b0; jaddr = 5'd12; rf_rdata = 32'h0C0C0C0C;
    step();
    chk("hs_new_capture", {27'd0, rf_jaddr}, 32'd12);
    wait_ack(n);
    chk("hs_new_rdata", rdata, 32'h0C0C0C0C);
    release_req();

    // Reset while starving in PEND with hold raised.
    dut_jw = 0;
    req = 1'b1; jwe = 1'b1; jaddr = 5'd8; jwdata = 32'h88888888;
    step();
    ex_we = 1'b1; ex_waddr = 5'd7; ex_wdata = 32'h70707070;
    repeat (SMAX) step();
    chk("rst_mid_hold_pre", {31'd0, hold}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_ack", {31'd0, ack}, 32'd0);
    chk("rst_mid_hold", {31'd0, hold}, 32'd0);
    chk("rst_mid_rdata", rdata, 32'd0);
    chk("rst_mid_jaddr", {27'd0, rf_jaddr}, 32'd0);
    chk("rst_mid_rf_addr", {27'd0, rf_waddr}, 32'd7);
    model_reset();
    ex_we = 1'b0; req = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    repeat (6) step();
    chk("rst_mid_no_write", dut_jw, 32'd0);

    // Random traffic with EX backing off whenever hold is raised.
    for (int t = 0; t < 200; t++) begin
      rwe = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      run_xact(rwe, ra, $urandom, $urandom, 0, 5'd0, 1'b1, lat, nw);
      enw = (rwe && ra != 5'd0) ? ((MIR && !ra[4]) ? 2 : 1) : 0;
      chk("rnd_nwr", nw, enw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/regs_wport_arbiter.md
# regs_wport_arbiter

Arbitrates the single register-file write port between the EX write-back path and the JTAG debug port. It also sequences JTAG register reads. It sits between `ex`/`jtag_dm` and `regs`, and drives that block's `we_i`/`waddr_i`/`wdata_i` and `jtag_addr_i` inputs. EX write-back always has priority; a starvation counter requests a pipeline hold so that a pending JTAG access is guaranteed to complete.

## Interface
- `STARVE_MAX`, 4: consecutive blocked cycles with a JTAG write pending before `hold_ex_o` asserts; legal range 1..15.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ex_we_i` in 1: EX write-back enable.
- `ex_waddr_i` in 5: EX write-back register address.
- `ex_wdata_i` in 32: EX write-back data.
- `jtag_req_i` in 1: JTAG access request, four-phase handshake.
- `jtag_we_i` in 1: 1 = write, 0 = read; sampled with request.
- `jtag_addr_i` in 5: JTAG register address; sampled with request.
- `jtag_wdata_i` in 32: JTAG write data; sampled with request.
- `jtag_ack_o` out 1: access complete; held until `jtag_req_i` falls.
- `jtag_rdata_o` out 32: read data; valid while `jtag_ack_o`=1 for reads.
- `rf_rdata_i` in 32: `regs` JTAG read data (`jtag_data_o`).
- `rf_we_o` out 1: register-file write enable.
- `rf_waddr_o` out 5: register-file write address.
- `rf_wdata_o` out 32: register-file write data.
- `rf_jtag_addr_o` out 5: register-file JTAG read address; equals the captured address.
- `hold_ex_o` out 1: registered stall request to the pipeline controller.

## Operation
- **Capture.** Capture registers `cap_we`, `cap_addr`, `cap_data` load in IDLE when `jtag_req_i`=1.
- **EX slot.** `ex_slot` = `ex_we_i` && `ex_waddr_i`≠0. The rf port carries EX combinationally whenever `ex_slot`=1.
- **States.**
  - IDLE: if `jtag_req_i`=1, capture and go to PEND.
  - PEND, read: go to ACK. `rdata_q` <= `rf_rdata_i` on this edge.
  - PEND, write: if `cap_addr`=0, go to ACK with no write. Else if `ex_slot`=0, drive the rf port with `cap_addr`/`cap_data` this cycle, then go to MIRROR (macro on and `cap_addr` in 1..15) or to ACK. Else stay in PEND and increment `starve_cnt`.
  - MIRROR: when `ex_slot`=0, write `cap_data` to `cap_addr`+16, then go to ACK. Otherwise stay and increment `starve_cnt`.
  - ACK: `jtag_ack_o`=1. When `jtag_req_i`=0, go to IDLE.
- **Starvation hold.** `hold_ex_o` <= 1 when the next `starve_cnt` value ≥ `STARVE_MAX`. `starve_cnt` and `hold_ex_o` clear on the edge that performs the JTAG write. They also clear on any exit from PEND/MIRROR. `starve_cnt` is 4 bits and saturates at 15.
- **Read data.** `jtag_rdata_o` = `rdata_q`. `regs` forwards an in-flight EX write onto its read port, so the read returns the freshly written value.
- **Ignored input changes.** A new request is ignored outside IDLE. Input changes after capture have no effect.

## Timing
- **Reset values.** State IDLE; `jtag_ack_o`=0, `hold_ex_o`=0, `jtag_rdata_o`=0, `starve_cnt`=0, capture registers 0. `rf_rdata_i` feeds nothing on reset.
- **Combinational outputs.** `rf_we_o`/`rf_waddr_o`/`rf_wdata_o` are combinational (EX mux or JTAG slot). With no access they follow `ex_*`, with `rf_we_o` = `ex_we_i`. `rf_jtag_addr_o` = `cap_addr`.
- **Uncontended latency.** `jtag_req_i` sampled at edge 0. The write or read occurs in cycle 1. `jtag_ack_o`=1 from edge 2. With mirroring, ack is one cycle later.
- **Contention.** Each cycle with `ex_slot`=1 during PEND or MIRROR adds one cycle. `hold_ex_o` rises `STARVE_MAX` edges after the first blocked cycle. The pipeline drops `ex_we_i` no later than the cycle after `hold_ex_o` rises.
- **Same-cycle conflict.** If EX and JTAG target the same cycle, EX wins and JTAG retries. No write is ever lost or merged.
- **Mid-operation reset.** Asynchronous reset aborts any pending access with no partial mirror completion. `jtag_ack_o` falls immediately.

## Configuration
- **`QED_MIRROR_EN` defined.** A JTAG write to x1..x15 also writes x16..x31 via the MIRROR state. This keeps original and duplicate registers equal so QED consistency is preserved across debug writes. A JTAG write to x16..x31 is not mirrored.
- **`QED_MIRROR_EN` undefined.** The MIRROR state does not exist. Every JTAG write is a single rf write.

## Test plan
- **Uncontended write.** Idle EX; JTAG write x3=0xDEADBEEF. `rf_we_o`=1, addr 3, in cycle 1; ack at edge 2. With `QED_MIRROR_EN`, also a write to x19 in cycle 2 and ack at edge 3.
- **Read.** JTAG read x5 while `rf_rdata_i`=0x1234. `jtag_rdata_o`=0x1234 with ack at edge 2; no rf write occurs.
- **Starvation.** EX writes x7 every cycle, `STARVE_MAX`=4, JTAG write pending. `hold_ex_o`=1 after 4 blocked cycles. The JTAG write lands in the first cycle `ex_we_i`=0, and hold clears on that edge.
- **x0 write.** JTAG write to x0. Ack at edge 2 and `rf_we_o` never driven by JTAG. An EX write to x0 does not block the slot.
- **Handshake.** `jtag_req_i` held high for 10 cycles after ack. Ack stays high, with no second access. Req falls, then ack falls next edge, and a new request is accepted.
- **Reset mid-operation.** Assert `rst` while in PEND with `hold_ex_o`=1. All outputs go to reset values immediately, and no JTAG write occurs after release.
